nibble_serial_adder: RTL
========================

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits; it SHALL be a multiple of 4 and at least 4; N = WIDTH/4 is the number of nibbles.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port start, input, 1 bit: request to begin an addition; sampled only in IDLE.
REQ-006 Port a, input, WIDTH bits: operand A; sampled on the accepted start edge.
REQ-007 Port b, input, WIDTH bits: operand B; sampled on the accepted start edge.
REQ-008 Port c_in, input, 1 bit: initial carry into nibble 0; sampled on the accepted start edge.
REQ-009 Port busy, output, 1 bit: high while nibbles are being added.
REQ-010 Port done, output, 1 bit: single-cycle pulse marking sum, c_out and ovf as final.
REQ-011 Port sum, output, WIDTH bits: registered result of a + b + c_in, modulo 2^WIDTH.
REQ-012 Port c_out, output, 1 bit: carry out of bit WIDTH-1.
REQ-013 Port ovf, output, 1 bit: two's-complement signed overflow flag.

Function
REQ-014 The FSM SHALL have three states, IDLE, RUN and DONE; busy = (state==RUN) and done = (state==DONE), both decoded from registered state.
REQ-015 IDLE with start=1: the block SHALL latch a, b and c_in into internal registers, clear sum to 0, set the nibble index to 0 and go to RUN.
REQ-016 IDLE with start=0: the block SHALL stay in IDLE and hold all outputs.
REQ-017 Each RUN cycle SHALL add exactly one 4-bit nibble i (bits 4i+3..4i) of the latched operands plus the carry register using one internal 4-bit ripple-carry slice.
REQ-018 Each RUN cycle SHALL write the slice result into sum[4i+3:4i], load the slice carry-out into the carry register and increment i.
REQ-019 In nibble 0 the carry register SHALL hold the latched c_in.
REQ-020 On the RUN cycle with i = N-1, the block SHALL set c_out = slice carry-out, set ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1), and go to DONE.
REQ-021 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-022 Latency: with start accepted at edge k, busy SHALL be high for edges k+1..k+N and done SHALL be high for the cycle after edge k+N.
REQ-023 start SHALL be ignored in RUN and DONE; operand or c_in changes after acceptance SHALL NOT affect the result.
REQ-024 sum, c_out and ovf SHALL hold their final values from DONE until the next accepted start.
REQ-025 A back-to-back start is legal in the first IDLE cycle after DONE.
REQ-026 Partially written sum bits are visible during RUN; they are valid only when done=1 or later.
REQ-027 The nibble index SHALL be ceil(log2(N)) bits wide, minimum 1, and SHALL NOT wrap within one operation.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL go to IDLE and set busy=0, done=0, sum=0, c_out=0, ovf=0, clear the carry register and clear the nibble index; this reset takes priority over start.
REQ-029 Reset in RUN or DONE SHALL abort the operation with no done pulse; the first start after rst deasserts SHALL be accepted normally.

Verification
REQ-030 WIDTH=16, a=0x0001, b=0xFFFF, c_in=0 -> done 5 cycles after the start edge; sum=0x0000, c_out=1, ovf=0; busy high for exactly 4 cycles.
REQ-031 a=0x7FFF, b=0x0001, c_in=0 -> sum=0x8000, c_out=0, ovf=1; a=0x8000, b=0x8000 -> sum=0x0000, c_out=1, ovf=1.
REQ-032 a=0x1234, b=0x4321, c_in=1; during RUN drive start=1 and change a to 0xFFFF -> single done pulse with sum=0x5556, c_out=0, ovf=0.
REQ-033 rst=1 on the 2nd RUN cycle -> next cycle busy=0, done=0, sum=0x0000, c_out=0, ovf=0; no done pulse follows; a new start one cycle later produces a correct result.
REQ-034 Two operations: start held high through DONE -> start ignored during DONE; second operation accepted in the next IDLE cycle; first result holds until that accept.
REQ-035 WIDTH=4, a=0xF, b=0x1, c_in=1 -> done 2 cycles after the start edge; sum=0x1, c_out=1, ovf=0.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Adds two WIDTH-bit operands plus a carry-in, one 4-bit nibble per clock,
// using a single 4-bit ripple-carry slice. An accepted start latches the
// operands. RUN then lasts WIDTH/4 cycles, and a one-cycle DONE pulse follows.
//
// Ports
//    clk    in   1      clock; all state updates on the rising edge
//    rst    in   1      synchronous active-high reset (priority over start)
//    start  in   1      begin an addition; only sampled in IDLE
//    a      in   WIDTH  operand A, latched on the accepted start edge
//    b      in   WIDTH  operand B, latched on the accepted start edge
//    c_in   in   1      carry into nibble 0, latched on the accepted start edge
//    busy   out  1      high while nibbles are being added (state RUN)
//    done   out  1      single-cycle pulse: sum/c_out/ovf are final (state DONE)
//    sum    out  WIDTH  (a + b + c_in) mod 2^WIDTH, built up nibble by nibble
//    c_out  out  1      carry out of bit WIDTH-1
//    ovf    out  1      two's-complement signed overflow
// -----------------------------------------------------------------------------
module nibble_serial_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf
);

   localparam int N  = WIDTH / 4;
   localparam int IW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;

   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_c_out;
   logic             r_ovf;
   logic [IW-1:0]    r_idx;

   logic [3:0]       w_a_nibs [N];
   logic [3:0]       w_b_nibs [N];
   logic [3:0]       w_a_nib;
   logic [3:0]       w_b_nib;
   logic [3:0]       w_slice_sum;
   logic [4:0]       w_c;          // w_c[k] = carry into bit k of the slice
   logic             w_last;
   logic [WIDTH-1:0] w_sum_next;

   // Split the latched operands into nibbles so the slice input is a plain mux.
   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_nib
         assign w_a_nibs[gi] = r_a[4*gi +: 4];
         assign w_b_nibs[gi] = r_b[4*gi +: 4];
      end
   endgenerate

   assign w_a_nib = w_a_nibs[r_idx];
   assign w_b_nib = w_b_nibs[r_idx];

   // The one 4-bit ripple-carry slice shared by every nibble.
   assign w_c[0] = r_carry;
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_fa
         assign w_slice_sum[gi] = w_a_nib[gi] ^ w_b_nib[gi] ^ w_c[gi];
         assign w_c[gi+1]       = (w_a_nib[gi] & w_b_nib[gi]) |
                                  (w_c[gi] & (w_a_nib[gi] ^ w_b_nib[gi]));
      end
   endgenerate

   assign w_last = (r_idx == IW'(N - 1));

   // Merge the slice result into the nibble currently being worked on.
   always_comb begin
      w_sum_next = r_sum;
      for (int i = 0; i < N; i++) begin
         if (r_idx == IW'(i)) begin
            w_sum_next[4*i +: 4] = w_slice_sum;
         end
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start) w_state_next = RUN;
         RUN:     if (w_last) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Datapath. c_out and ovf are written only on the last nibble, so they keep
   // the previous result until a new operation completes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_c_out <= 1'b0;
         r_ovf   <= 1'b0;
         r_idx   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_b     <= b;
                  r_carry <= c_in;
                  r_sum   <= '0;
                  r_idx   <= '0;
               end
            end
            RUN: begin
               r_sum   <= w_sum_next;
               r_carry <= w_c[4];
               if (w_last) begin
                  r_c_out <= w_c[4];
                  // Carry into the MSB differs from carry out of it only on
                  // signed overflow.
                  r_ovf   <= w_c[3] ^ w_c[4];
               end else begin
                  // Hold the index on the last nibble so it never wraps.
                  r_idx   <= r_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy  = (r_state == RUN);
   assign done  = (r_state == DONE);
   assign sum   = r_sum;
   assign c_out = r_c_out;
   assign ovf   = r_ovf;

endmodule
